// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the multicycle PC fetch sequencer:
// PC-source encodings, FSM state encoding, word size and a branch offset helper.
package pc_fetch_sequencer_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BEQ = 2'b01;
    localparam logic [1:0] PCSRC_BNE = 2'b10;
    localparam logic [1:0] PCSRC_JMP = 2'b11;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FETCH  = 2'b01,
        DECODE = 2'b10,
        UPDATE = 2'b11
    } state_t;

    // Signed word offset converted to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for sequential, BEQ, BNE and J/JAL flow.
// taken flags any rule-selected non-sequential target, even if it equals pc+4.
module pc_next_calc
    import pc_fetch_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_source,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    output logic [31:0] next_pc,
    output logic        taken
);

    logic [31:0] seq_pc_s;
    logic [31:0] btarget_s;
    logic [31:0] jtarget_full_s;

    assign seq_pc_s       = pc + WORD_BYTES;
    assign btarget_s      = seq_pc_s + branch_offset(imm16);
    assign jtarget_full_s = {seq_pc_s[31:28], jtarget, 2'b00};

    // Select the target from the latched source code and zero flag.
    always_comb begin
        next_pc = seq_pc_s;
        taken   = 1'b0;
        case (pc_source)
            PCSRC_SEQ: begin
                next_pc = seq_pc_s;
                taken   = 1'b0;
            end
            PCSRC_BEQ: begin
                if (zero) begin
                    next_pc = btarget_s;
                    taken   = 1'b1;
                end else begin
                    next_pc = seq_pc_s;
                    taken   = 1'b0;
                end
            end
            PCSRC_BNE: begin
                if (!zero) begin
                    next_pc = btarget_s;
                    taken   = 1'b1;
                end else begin
                    next_pc = seq_pc_s;
                    taken   = 1'b0;
                end
            end
            PCSRC_JMP: begin
                next_pc = jtarget_full_s;
                taken   = 1'b1;
            end
            default: begin
                next_pc = seq_pc_s;
                taken   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multicycle PC sequencer: IDLE -> FETCH -> DECODE -> UPDATE -> FETCH ...
// Owns the PC register and the retired-instruction counter.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic        dec_valid,
    input  logic [1:0]  pc_source,
    input  logic        zero_flag,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        pc_write,
    output logic        branch_taken,
    output logic [31:0] retired,
    output logic        trap
);

    state_t      state_r;
    logic [1:0]  src_r;
    logic        zero_r;
    logic [15:0] imm_r;
    logic [25:0] jt_r;
    logic [31:0] next_pc_s;
    logic        taken_s;

    assign pc_plus4 = pc + WORD_BYTES;

`ifndef PC_MISALIGN_TRAP_EN
    logic unused_trap_vector_s;
    assign unused_trap_vector_s = ^TRAP_VECTOR;
`endif

    pc_next_calc u_next (
        .pc        (pc),
        .pc_source (src_r),
        .zero      (zero_r),
        .imm16     (imm_r),
        .jtarget   (jt_r),
        .next_pc   (next_pc_s),
        .taken     (taken_s)
    );

    // Sequencer FSM with PC register, decode latches, counter and registered strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            pc_write     <= 1'b0;
            branch_taken <= 1'b0;
            trap         <= 1'b0;
            retired      <= 32'd0;
            src_r        <= PCSRC_SEQ;
            zero_r       <= 1'b0;
            imm_r        <= 16'd0;
            jt_r         <= 26'd0;
        end else begin
            pc_write     <= 1'b0;
            branch_taken <= 1'b0;
            trap         <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r  <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        state_r  <= DECODE;
                        imem_req <= 1'b0;
                    end else begin
                        state_r  <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                DECODE: begin
                    imem_req <= 1'b0;
                    if (dec_valid) begin
                        src_r   <= pc_source;
                        zero_r  <= zero_flag;
                        imm_r   <= imm16;
                        jt_r    <= jtarget;
                        state_r <= UPDATE;
                    end else begin
                        state_r <= DECODE;
                    end
                end
                UPDATE: begin
                    state_r  <= FETCH;
                    imem_req <= 1'b1;
                    pc_write <= 1'b1;
                    retired  <= retired + 32'd1;
`ifdef PC_MISALIGN_TRAP_EN
                    if (next_pc_s[1:0] != 2'b00) begin
                        pc           <= TRAP_VECTOR;
                        trap         <= 1'b1;
                        branch_taken <= 1'b0;
                    end else begin
                        pc           <= next_pc_s;
                        trap         <= 1'b0;
                        branch_taken <= taken_s;
                    end
`else
                    pc           <= next_pc_s;
                    branch_taken <= taken_s;
`endif
                end
                default: begin
                    state_r  <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
